// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory-stage controller: controller state
// encoding and the data-path word width.
package mem_stage_pkg;

    localparam int WORD_W = 16;

    // Controller states. ERR is terminal until reset.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt
// Wait counter for an outstanding memory access. Cleared when a request is
// launched and advanced once per request/wait cycle. tc flags the last
// cycle the controller may still accept a completion.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   clr  in   restart count at zero
//   en   in   advance count by one
//   tc   out  count has reached MAX_WAIT-1
module mem_timeout_cnt #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller behind the execute-stage ALU. Non-memory ops are
// passed straight through as a writeback beat; loads/stores are launched to
// a stalling data memory and the execute stage is held until the access
// completes. Unaligned accesses, read+write conflicts and memory timeouts
// park the controller in a sticky error state until reset.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid / ex_ready      execute-stage handshake
//   ex_alu_out               address for memory ops, else writeback value
//   ex_wdata                 store data
//   ex_mem_read/ex_mem_write op is a load / store
//   mem_addr, mem_wdata      registered memory address / write data
//   mem_rd, mem_wr           memory read / write request
//   mem_busy                 memory cannot take the request this cycle
//   mem_done, mem_rdata      access complete, load data
//   wb_valid                 one-cycle writeback beat
//   wb_data, wb_is_load      beat payload, beat carries load data
//   err                      sticky fault flag
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [WORD_W-1:0] ex_alu_out,
    input  logic [WORD_W-1:0] ex_wdata,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_data,
    output logic              wb_is_load,
    output logic              err
);

    state_t state;
    logic   ld_q;       // outstanding access is a load
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_tc;
    logic   is_mem;
    logic   done_ok;

    // Request strobes decode from flops only so they are glitch-free.
    assign ex_ready = (state == IDLE);
    assign mem_rd   = (state == REQ) &&  ld_q;
    assign mem_wr   = (state == REQ) && !ld_q;

    assign is_mem  = ex_mem_read || ex_mem_write;

    // While busy the memory has not taken the request, so a done in that
    // cycle cannot belong to it.
    assign done_ok = ((state == REQ) && !mem_busy && mem_done) ||
                     ((state == WAIT) && mem_done);

    assign cnt_clr = ex_valid && ex_ready && is_mem;
    assign cnt_en  = (state == REQ) || (state == WAIT);

    mem_timeout_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ld_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_is_load <= 1'b0;
            err        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            wb_valid   <= 1'b1;
                            wb_data    <= ex_alu_out;
                            wb_is_load <= 1'b0;
                        end else if ((ex_mem_read && ex_mem_write) || ex_alu_out[0]) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            mem_addr  <= ex_alu_out;
                            mem_wdata <= ex_wdata;
                            ld_q      <= ex_mem_read;
                            state     <= REQ;
                        end
                    end
                end
                REQ, WAIT: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (done_ok) begin
                        wb_valid   <= 1'b1;
                        wb_data    <= ld_q ? mem_rdata : mem_addr;
                        wb_is_load <= ld_q;
                        state      <= IDLE;
                    end else if (cnt_tc) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if ((state == REQ) && !mem_busy) begin
                        state <= WAIT;
                    end
                end
                ERR: begin
                    err <= 1'b1;
                end
                default: state <= ERR;
            endcase
        end
    end

endmodule
